// File: rtl/mem_wb_pipe.sv
// LSU-to-writeback pipeline register: NCH retire lanes through a 2-entry skid buffer.
// Optional WAW squash of older same-address lane writes under MEM_WB_WAW_SQUASH_EN.
module mem_wb_pipe #(
  parameter int NCH    = 1,
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CSR_AW = 12,
  parameter int CNT_W  = $clog2(NCH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [NCH-1:0]        lane_vld_i,
  input  logic [NCH-1:0]        rd_we_i,
  input  logic [NCH*RA_W-1:0]   rd_wa_i,
  input  logic [NCH*XLEN-1:0]   rd_wd_i,
  input  logic [NCH-1:0]        csr_we_i,
  input  logic [NCH*CSR_AW-1:0] csr_waddr_i,
  input  logic [NCH*XLEN-1:0]   csr_wdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [NCH-1:0]        rd_we_o,
  output logic [NCH*RA_W-1:0]   rd_wa_o,
  output logic [NCH*XLEN-1:0]   rd_wd_o,
  output logic [NCH-1:0]        csr_we_o,
  output logic [NCH*CSR_AW-1:0] csr_waddr_o,
  output logic [NCH*XLEN-1:0]   csr_wdata_o,
  output logic [CNT_W-1:0]      instret_incr_o
);

  typedef struct packed {
    logic [NCH-1:0]        lane_vld;
    logic [NCH-1:0]        rd_we;
    logic [NCH*RA_W-1:0]   rd_wa;
    logic [NCH*XLEN-1:0]   rd_wd;
    logic [NCH-1:0]        csr_we;
    logic [NCH*CSR_AW-1:0] csr_waddr;
    logic [NCH*XLEN-1:0]   csr_wdata;
  } entry_t;

  entry_t         main_q;
  entry_t         skid_q;
  entry_t         in_ent;
  logic           main_valid;
  logic           skid_valid;
  logic           accept;
  logic           xfer;
  logic [NCH-1:0] rd_gv;
  logic [NCH-1:0] csr_gv;
  logic [NCH-1:0] rd_keep;
  logic [NCH-1:0] csr_keep;
  logic [CNT_W-1:0] retire_cnt;

  assign in_ready_o  = !skid_valid;
  assign out_valid_o = main_valid;
  assign accept      = in_valid_i && !skid_valid;
  assign xfer        = main_valid && out_ready_i;

  // Enables are lane-gated before storage so the squash compare sees only live writes.
  always_comb begin
    rd_gv    = rd_we_i & lane_vld_i;
    csr_gv   = csr_we_i & lane_vld_i;
    rd_keep  = rd_gv;
    csr_keep = csr_gv;
`ifdef MEM_WB_WAW_SQUASH_EN
    for (int i = 0; i < NCH; i++) begin
      for (int j = i + 1; j < NCH; j++) begin
        if (rd_gv[i] && rd_gv[j] &&
            rd_wa_i[i*RA_W +: RA_W] == rd_wa_i[j*RA_W +: RA_W] &&
            rd_wa_i[i*RA_W +: RA_W] != '0)
          rd_keep[i] = 1'b0;
        if (csr_gv[i] && csr_gv[j] &&
            csr_waddr_i[i*CSR_AW +: CSR_AW] == csr_waddr_i[j*CSR_AW +: CSR_AW])
          csr_keep[i] = 1'b0;
      end
    end
`endif
    in_ent.lane_vld  = lane_vld_i;
    in_ent.rd_we     = rd_keep;
    in_ent.rd_wa     = rd_wa_i;
    in_ent.rd_wd     = rd_wd_i;
    in_ent.csr_we    = csr_keep;
    in_ent.csr_waddr = csr_waddr_i;
    in_ent.csr_wdata = csr_wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush_i) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || xfer) begin
      // SKID is always older than the input, so it refills MAIN first.
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= in_ent;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= in_ent;
      skid_valid <= 1'b1;
    end
  end

  always_comb begin
    retire_cnt = '0;
    for (int k = 0; k < NCH; k++)
      retire_cnt = retire_cnt + CNT_W'(main_q.lane_vld[k]);
  end

  assign rd_we_o        = main_valid ? (main_q.rd_we & main_q.lane_vld) : '0;
  assign csr_we_o       = main_valid ? (main_q.csr_we & main_q.lane_vld) : '0;
  assign rd_wa_o        = main_valid ? main_q.rd_wa : '0;
  assign rd_wd_o        = main_valid ? main_q.rd_wd : '0;
  assign csr_waddr_o    = main_valid ? main_q.csr_waddr : '0;
  assign csr_wdata_o    = main_valid ? main_q.csr_wdata : '0;
  assign instret_incr_o = xfer ? retire_cnt : '0;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe with NCH=2: directed bundles, a 2-deep FIFO reference model
// checked every cycle, plus literal expectations per scenario.
module tb_mem_wb_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  lane_vld;
  logic [1:0]  rd_we;
  logic [9:0]  rd_wa;
  logic [63:0] rd_wd;
  logic [1:0]  csr_we;
  logic [23:0] csr_waddr;
  logic [63:0] csr_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  wb_rd_we;
  logic [9:0]  wb_rd_wa;
  logic [63:0] wb_rd_wd;
  logic [1:0]  wb_csr_we;
  logic [23:0] wb_csr_waddr;
  logic [63:0] wb_csr_wdata;
  logic [1:0]  instret_incr;

  mem_wb_pipe #(.NCH(2), .XLEN(32), .RA_W(5), .CSR_AW(12)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .lane_vld_i(lane_vld), .rd_we_i(rd_we), .rd_wa_i(rd_wa), .rd_wd_i(rd_wd),
    .csr_we_i(csr_we), .csr_waddr_i(csr_waddr), .csr_wdata_i(csr_wdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .rd_we_o(wb_rd_we), .rd_wa_o(wb_rd_wa), .rd_wd_o(wb_rd_wd),
    .csr_we_o(wb_csr_we), .csr_waddr_o(wb_csr_waddr), .csr_wdata_o(wb_csr_wdata),
    .instret_incr_o(instret_incr)
  );

  typedef struct packed {
    logic [1:0]  lv;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [1:0]  cwe;
    logic [23:0] ca;
    logic [63:0] cd;
  } bun_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  bun_t q[$];
  bun_t mh;
  bun_t wb;
  bit   acc;
  bit   xf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bun_t mk(input logic [7:0] n, input logic [1:0] lv, input logic [1:0] we);
    bun_t b;
    b.lv  = lv;
    b.we  = we;
    b.wa  = {5'(n + 8'd1), 5'(n)};
    b.wd  = {32'h1000 + 32'(n), 32'h100 + 32'(n)};
    b.cwe = we;
    b.ca  = {12'h301 + 12'(n), 12'h300 + 12'(n)};
    b.cd  = {32'hC001 + 32'(n), 32'hC000 + 32'(n)};
    return b;
  endfunction

  // Younger lane 1 overrides lane 0 when both write the same destination.
  function automatic logic [1:0] gpr_eff(input bun_t b);
    logic [1:0] e;
    e = b.we & b.lv;
`ifdef MEM_WB_WAW_SQUASH_EN
    if (e == 2'b11 && b.wa[4:0] == b.wa[9:5] && b.wa[4:0] != 5'd0) e[0] = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [1:0] csr_eff(input bun_t b);
    logic [1:0] e;
    e = b.cwe & b.lv;
`ifdef MEM_WB_WAW_SQUASH_EN
    if (e == 2'b11 && b.ca[11:0] == b.ca[23:12]) e[0] = 1'b0;
`endif
    return e;
  endfunction

  task automatic drive(input bun_t b, input logic v);
    in_valid  = v;
    lane_vld  = b.lv;
    rd_we     = b.we;
    rd_wa     = b.wa;
    rd_wd     = b.wd;
    csr_we    = b.cwe;
    csr_waddr = b.ca;
    csr_wdata = b.cd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: the stage behaves as an in-order queue holding at most two bundles.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() > 0) begin
        mh = q[0];
        chk("m_vld", out_valid, 1);
        chk("m_rd_we", wb_rd_we, gpr_eff(mh));
        chk("m_rd_wa", wb_rd_wa, mh.wa);
        chk("m_rd_wd", wb_rd_wd, mh.wd);
        chk("m_csr_we", wb_csr_we, csr_eff(mh));
        chk("m_csr_a", wb_csr_waddr, mh.ca);
        chk("m_csr_d", wb_csr_wdata, mh.cd);
        chk("m_incr", instret_incr, out_ready ? $countones(mh.lv) : 0);
      end else begin
        chk("m_idle_vld", out_valid, 0);
        chk("m_idle_we", {wb_csr_we, wb_rd_we}, 0);
        chk("m_idle_a", {wb_rd_wa, wb_csr_waddr}, 0);
        chk("m_idle_wd", wb_rd_wd, 0);
        chk("m_idle_cd", wb_csr_wdata, 0);
        chk("m_idle_incr", instret_incr, 0);
      end
      chk("m_rdy", in_ready, (q.size() < 2) ? 1 : 0);
      acc = in_valid && (q.size() < 2);
      xf  = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (xf) void'(q.pop_front());
        if (acc) q.push_back({lane_vld, rd_we, rd_wa, rd_wd, csr_we, csr_waddr, csr_wdata});
      end
    end
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive('0, 1'b0);
    #2;
    chk("rst_vld", out_valid, 0);
    chk("rst_rdy", in_ready, 1);
    chk("rst_incr", instret_incr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc();

    // Back-to-back streaming, full throughput
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      drive(mk(8'(n), 2'b11, 2'b11), 1'b1);
      cyc();
      #1;
      chk("stream_wd", wb_rd_wd[31:0], 32'h100 + 32'(n));
      chk("stream_incr", instret_incr, 2);
      chk("stream_rdy", in_ready, 1);
    end
    drive('0, 1'b0);
    cyc();

    // Backpressure: A held, B skidded, C refused until space frees
    out_ready = 1'b0;
    drive(mk(8'h10, 2'b11, 2'b11), 1'b1);
    cyc();
    drive(mk(8'h11, 2'b11, 2'b11), 1'b1);
    #1 chk("bp_rdy_a", in_ready, 1);
    cyc();
    drive(mk(8'h12, 2'b11, 2'b11), 1'b1);
    #1 chk("bp_rdy_b", in_ready, 0);
    chk("bp_hold_a", wb_rd_wd[31:0], 32'h110);
    chk("bp_hold_incr", instret_incr, 0);
    cyc();
    #1 chk("bp_c_blk", in_ready, 0);
    cyc();
    #1 chk("bp_hold_a2", wb_rd_wd[31:0], 32'h110);
    out_ready = 1'b1;
    #1 chk("bp_rel_incr", instret_incr, 2);
    cyc();
    #1 chk("bp_out_b", wb_rd_wd[31:0], 32'h111);
    cyc();
    drive('0, 1'b0);
    #1 chk("bp_out_c", wb_rd_wd[31:0], 32'h112);
    cyc();
    #1 chk("bp_drain", out_valid, 0);

    // Flush with both entries full and a third bundle offered
    out_ready = 1'b0;
    drive(mk(8'h20, 2'b11, 2'b11), 1'b1);
    cyc();
    drive(mk(8'h21, 2'b11, 2'b11), 1'b1);
    cyc();
    drive(mk(8'h22, 2'b11, 2'b11), 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive('0, 1'b0);
    out_ready = 1'b1;
    #1 chk("fl_vld", out_valid, 0);
    chk("fl_rdy", in_ready, 1);
    chk("fl_incr", instret_incr, 0);
    cyc();
    #1 chk("fl_vld2", out_valid, 0);

    // Lane gating
    drive(mk(8'h30, 2'b01, 2'b11), 1'b1);
    cyc();
    drive('0, 1'b0);
    #1 chk("lg_rd_we", wb_rd_we, 2'b01);
    chk("lg_csr_we", wb_csr_we, 2'b01);
    chk("lg_incr", instret_incr, 1);
    cyc();

    // Both lanes write x5
    wb    = mk(8'h40, 2'b11, 2'b11);
    wb.wa = {5'd5, 5'd5};
    wb.wd = {32'hBBBB, 32'hAAAA};
    drive(wb, 1'b1);
    cyc();
    drive('0, 1'b0);
`ifdef MEM_WB_WAW_SQUASH_EN
    #1 chk("waw_we", wb_rd_we, 2'b10);
`else
    #1 chk("waw_we", wb_rd_we, 2'b11);
`endif
    chk("waw_incr", instret_incr, 2);
    chk("waw_wd1", wb_rd_wd[63:32], 32'hBBBB);
    cyc();

    // Async reset with both entries full and a transfer pending
    out_ready = 1'b0;
    drive(mk(8'h50, 2'b11, 2'b11), 1'b1);
    cyc();
    drive(mk(8'h51, 2'b11, 2'b11), 1'b1);
    cyc();
    out_ready = 1'b1;
    #1 rst = 1'b1;
    drive('0, 1'b0);
    #1 chk("ar_vld", out_valid, 0);
    chk("ar_rdy", in_ready, 1);
    chk("ar_we", {wb_csr_we, wb_rd_we}, 0);
    chk("ar_incr", instret_incr, 0);
    chk("ar_wd", wb_rd_wd, 0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    #1 chk("ar_post_vld", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
